// File: rtl/rgb_pwm_fsm.sv
// RGB LED controller: two debounced buttons select mode, colour and brightness;
// a free-running PWM counter sets brightness, and a step counter paces BLINK and CYCLE.
module rgb_pwm_fsm #(
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned STEP_CYCLES     = 6000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw1_n,
    input  logic       sw2_n,
    output logic       rgb_r,
    output logic       rgb_g,
    output logic       rgb_b,
    output logic [1:0] mode,
    output logic [2:0] color_idx,
    output logic [1:0] level
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ST_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned TH_W = PWM_BITS + 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CYCLE = 2'd3
    } mode_t;

    mode_t              state;
    mode_t              state_nxt;
    logic [2:0]         color_nxt;
    logic [1:0]         level_nxt;
    logic               phase;
    logic               phase_nxt;
    logic [ST_W-1:0]    step_cnt;
    logic [ST_W-1:0]    step_nxt;
    logic               step_wrap_c;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [TH_W-1:0]    thr_c;
    logic [2:0]         col_c;
    logic               en_c;
    logic [2:0]         lit_c;

    // Index 0 is the mode button, index 1 the select button.
    logic [1:0]         raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         deb;
    logic [1:0]         press;
    logic [DB_W-1:0]    db_cnt [2];

    assign raw  = {sw2_n, sw1_n};
    assign mode = 2'(state);

    function automatic logic [2:0] color_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b100;
            3'd1:    return 3'b110;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            3'd4:    return 3'b001;
            3'd5:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] next_color(input logic [2:0] idx);
        return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    // Synchronize, debounce and turn each released->pressed transition into a one-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            deb   <= 2'b11;
            press <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                        press[i]  <= ~sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Mode/colour/level state register plus step and PWM timebases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MODE_OFF;
            color_idx <= 3'd0;
            level     <= 2'd3;
            phase     <= 1'b1;
            step_cnt  <= '0;
            pwm_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            color_idx <= color_nxt;
            level     <= level_nxt;
            phase     <= phase_nxt;
            step_cnt  <= step_nxt;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Next-state logic; the select action uses the mode held before any mode change.
    always_comb begin
        state_nxt   = state;
        color_nxt   = color_idx;
        level_nxt   = level;
        phase_nxt   = phase;
        step_wrap_c = (step_cnt == ST_W'(STEP_CYCLES - 1));
        step_nxt    = step_wrap_c ? '0 : step_cnt + ST_W'(1);

        if (press[1]) begin
            if (state == MODE_SOLID || state == MODE_BLINK) color_nxt = next_color(color_idx);
            else                                             level_nxt = level + 2'd1;
        end

        if (press[0]) begin
            case (state)
                MODE_OFF:   state_nxt = MODE_SOLID;
                MODE_SOLID: state_nxt = MODE_BLINK;
                MODE_BLINK: state_nxt = MODE_CYCLE;
                MODE_CYCLE: state_nxt = MODE_OFF;
                default:    state_nxt = MODE_OFF;
            endcase
            step_nxt = '0;
            if (state_nxt == MODE_BLINK) phase_nxt = 1'b1;
        end else if (step_wrap_c) begin
            if (state == MODE_CYCLE) color_nxt = next_color(color_idx);
            if (state == MODE_BLINK) phase_nxt = ~phase;
        end
    end

    // Per-channel lit decision; threshold is one bit wider so level 3 reaches full duty.
    always_comb begin
        thr_c = TH_W'({1'b0, level} + 3'd1) << (PWM_BITS - 2);
        col_c = color_rgb(color_idx);
        case (state)
            MODE_OFF:   en_c = 1'b0;
            MODE_BLINK: en_c = phase;
            default:    en_c = 1'b1;
        endcase
        lit_c = col_c & {3{en_c && ({1'b0, pwm_cnt} < thr_c)}};
    end

    // Registered LED drive at the configured polarity.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r <= ACTIVE_LOW;
            rgb_g <= ACTIVE_LOW;
            rgb_b <= ACTIVE_LOW;
        end else begin
            rgb_r <= lit_c[2] ? ~ACTIVE_LOW : ACTIVE_LOW;
            rgb_g <= lit_c[1] ? ~ACTIVE_LOW : ACTIVE_LOW;
            rgb_b <= lit_c[0] ? ~ACTIVE_LOW : ACTIVE_LOW;
        end
    end

endmodule
